cache_arbiter: RTL
==================

# cache_arbiter

Shares the single port of the set-associative write-back cache between NUM_REQ requesters (port 0 instruction fetch, port 1 load/store by default). Round-robin arbitration, one cache transaction at a time. The arbiter latches the winner's command, drives the cache until its miss flag drops, then returns read data with a one-cycle done pulse. Also keeps access and miss counters for performance measurement.

## Interface

Parameters:
- NUM_REQ, 2, number of requesters (≥2)
- ADDR_W, 32, byte address width
- DATA_W, 32, word width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- req_rd  in  NUM_REQ  per-requester read request, held until done
- req_wr  in  NUM_REQ  per-requester write request, held until done
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, slice i = requester i
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
- req_rdata  out  DATA_W  read data, valid while req_done≠0
- c_rd_req  out  1  cache read request
- c_wr_req  out  1  cache write request
- c_addr  out  ADDR_W  cache address
- c_wr_data  out  DATA_W  cache write data
- c_rd_data  in  DATA_W  cache registered read data
- c_miss  in  1  cache combinational miss/busy flag
- acc_cnt  out  32  completed transactions
- miss_cnt  out  32  transactions that saw c_miss=1

## Operation

- FSM states: IDLE, ISSUE, COMPLETE.
- IDLE: c_rd_req=c_wr_req=0. Requester i is pending if req_rd[i]|req_wr[i]. If any are pending, pick the first pending index searching from (last+1) mod NUM_REQ upward with wrap. Latch grant index, addr, wdata and op into registers. Op is write if req_wr[i], else read; both set means write. Then go to ISSUE and set last=grant.
- ISSUE: drive c_* from latched registers only. Exactly one of c_rd_req/c_wr_req is high. On the first ISSUE cycle, if c_miss=1, set missed flag. When c_miss=0, go to COMPLETE.
- COMPLETE: c_rd_req=c_wr_req=0, so the cache sees a request gap and re-arms its per-access reference pulse. req_done[grant]=1. req_rdata=c_rd_data (don't-care for writes). acc_cnt+=1. If the missed flag is set, miss_cnt+=1 and the flag clears. Then go to IDLE.
- Requester contract: hold req and operands until its done pulse, and deassert on the following edge. Changes after grant are ignored because latched values are used.
- Counters wrap modulo 2^32.
- Reset values: state=IDLE, last=NUM_REQ-1 (requester 0 wins first), all outputs 0, counters 0, missed=0. Reset mid-transaction abandons it with no done pulse. The cache is reset by the same rst.

## Timing

- Cache hit: request seen in cycle 0, c_req high in cycle 1, done in cycle 2. Next grant at the earliest in cycle 3.
- Cache miss: done = 2 + (cycles c_miss stays high) after the request.
- c_* outputs are registered/state-decoded. req_done is decoded from state. req_rdata is a combinational passthrough.
- Simultaneous requests: only one grant per IDLE cycle. A loser waits at most NUM_REQ-1 transactions (round-robin fairness).
- A new request arriving during ISSUE/COMPLETE is considered only in the next IDLE.

## Structure

- Shared package cache_arb_pkg holds: the state enum, the OP_RD/OP_WR encoding, and the counter width constant.
- Sub-module rr_picker: combinational, with inputs pending[NUM_REQ] and last, output grant index plus a valid bit. Reused by future arbiters.
- Top level holds the FSM, command latches, missed flag and counters.

## Test plan

- Single read, cache hit, port 0 addr 0x40 preloaded 0x1234_5678: req_done=01 in cycle 2 and req_rdata=0x1234_5678; acc_cnt=1, miss_cnt=0.
- Cold read miss, port 1, with c_miss held 5 cycles: done in cycle 7, miss_cnt=1. c_rd_req drops in COMPLETE.
- Both ports request every cycle after reset: grants alternate 0,1,0,1; no done pulse overlap; ≥1 idle-request cycle between consecutive c_req assertions.
- Port 0 sets req_rd and req_wr together, wdata 0xDEAD_BEEF: the cache sees a write only, and a later read returns 0xDEAD_BEEF.
- Port 1 changes addr after grant: the cache still sees the originally latched address.
- rst asserted during ISSUE: the next cycle shows state IDLE, c_req=0, no done pulse, counters 0, and port 0 wins the next contention.

Source files
------------

// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cache_arb_pkg
//  Description : Shared types and constants for the cache-port arbiter:
//                FSM state encoding, latched operation encoding and the
//                width of the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      COMPLETE = 2'd2
   } arb_state_t;

   // Latched operation encoding
   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // Width of the access / miss performance counters
   localparam int CNT_W = 32;

endpackage : cache_arb_pkg
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin picker. Returns the first pending
//                index found searching upward from (last+1) mod NUM_REQ,
//                wrapping around.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    pending  in   NUM_REQ  one bit per requester with an outstanding request
//    last     in   IDX_W    index granted most recently
//    grant    out  IDX_W    selected index (0 when valid=0)
//    valid    out  1        at least one requester is pending
// ============================================================================
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   grant,
   output logic               valid
);

   // Scan offsets from the farthest to the nearest; the final assignment
   // therefore belongs to the nearest pending index after 'last'.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (pending[(int'(last) + k) % NUM_REQ]) begin
            grant = IDX_W'((int'(last) + k) % NUM_REQ);
            valid = 1'b1;
         end
      end
   end

endmodule : rr_picker
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arbiter
//  Description : Shares the single cache port between NUM_REQ requesters
//                with round-robin arbitration, one transaction at a time.
//                The winner's command is latched, driven to the cache until
//                its miss flag drops, then completed with a one-cycle done
//                pulse. Counts completed transactions and missed ones.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk, rst     clock and synchronous active-high reset
//    req_rd/wr    per-requester read/write request, held until done
//    req_addr     packed addresses, slice i = requester i
//    req_wdata    packed write data, slice i = requester i
//    req_done     one-hot completion pulse
//    req_rdata    read data, valid while req_done != 0
//    c_rd_req     cache read request
//    c_wr_req     cache write request
//    c_addr       cache address
//    c_wr_data    cache write data
//    c_rd_data    cache registered read data
//    c_miss       cache combinational miss/busy flag
//    acc_cnt      completed transactions
//    miss_cnt     transactions that saw a miss
// ============================================================================
module cache_arbiter
   import cache_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_rd,
   input  logic [NUM_REQ-1:0]        req_wr,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [DATA_W-1:0]         req_rdata,
   output logic                      c_rd_req,
   output logic                      c_wr_req,
   output logic [ADDR_W-1:0]         c_addr,
   output logic [DATA_W-1:0]         c_wr_data,
   input  logic [DATA_W-1:0]         c_rd_data,
   input  logic                      c_miss,
   output logic [CNT_W-1:0]          acc_cnt,
   output logic [CNT_W-1:0]          miss_cnt
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [IDX_W-1:0]    r_grant;
   logic [IDX_W-1:0]    r_last;
   logic                r_op;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_missed;
   logic [CNT_W-1:0]    r_acc_cnt;
   logic [CNT_W-1:0]    r_miss_cnt;

   logic [NUM_REQ-1:0]  w_pending;
   logic [IDX_W-1:0]    w_pick;
   logic                w_pick_vld;

   assign w_pending = req_rd | req_wr;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .pending (w_pending),
      .last    (r_last),
      .grant   (w_pick),
      .valid   (w_pick_vld)
   );

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_pick_vld) w_state_nxt = ISSUE;
         ISSUE:    if (!c_miss)    w_state_nxt = COMPLETE;
         COMPLETE: w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State register, command latches, miss flag and counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_last     <= IDX_W'(NUM_REQ - 1);
         r_grant    <= '0;
         r_op       <= OP_RD;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_missed   <= 1'b0;
         r_acc_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (w_pick_vld) begin
                  r_grant <= w_pick;
                  r_last  <= w_pick;
                  // A simultaneous read+write request is treated as a write.
                  r_op    <= req_wr[w_pick] ? OP_WR : OP_RD;
                  r_addr  <= req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
                  r_wdata <= req_wdata[int'(w_pick)*DATA_W +: DATA_W];
               end
            end
            ISSUE: begin
               // c_miss can only be high from the first ISSUE cycle on
               // (the state is left as soon as it drops), so sampling it in
               // any ISSUE cycle is the same as sampling the first one.
               if (c_miss) r_missed <= 1'b1;
            end
            COMPLETE: begin
               r_acc_cnt <= r_acc_cnt + 1'b1;
               if (r_missed) r_miss_cnt <= r_miss_cnt + 1'b1;
               r_missed  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs: cache side is decoded from state and latched registers only,
   // so the cache sees a request gap in COMPLETE and IDLE.
   // ------------------------------------------------------------------
   assign c_rd_req  = (r_state == ISSUE) && (r_op == OP_RD);
   assign c_wr_req  = (r_state == ISSUE) && (r_op == OP_WR);
   assign c_addr    = r_addr;
   assign c_wr_data = r_wdata;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_done
      assign req_done[i] = (r_state == COMPLETE) && (r_grant == IDX_W'(i));
   end

   assign req_rdata = (r_state == COMPLETE) ? c_rd_data : '0;
   assign acc_cnt   = r_acc_cnt;
   assign miss_cnt  = r_miss_cnt;

endmodule : cache_arbiter
`default_nettype wire
